// File: rtl/gray2bin_arb_pkg.sv
// Shared constants and state encoding for the Gray-to-binary arbiter.
package gray2bin_arb_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_IDW   = 2;
    localparam int DEF_CNTW  = 16;

    // IDLE: output register empty; BUSY: output register holds one operand.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/gray2bin_arbiter_conv.sv
// Combinational Gray-to-binary converter, generic in WIDTH.
// Binary bit i is the XOR of all Gray bits at positions i and above.
module gray2bin_arbiter_conv #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^(gray_i >> i);
    end

endmodule

// File: rtl/gray2bin_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary converter among NREQ
// requesters. One registered operand feeds the converter; the result is
// tagged with the granted requester's index.
module gray2bin_arbiter
    import gray2bin_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = DEF_IDW,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_gray,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_bin,
    output logic [IDW-1:0]        rsp_id,
    input  logic                  rsp_ready,
    output logic [CNTW-1:0]       conv_count
);

    arb_state_e       state_q, state_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic can_accept;
    logic grant_vld;
    int   grant_idx;
    int   scan_idx;

    assign can_accept = (state_q == IDLE) || rsp_ready;

    // Round-robin pick: first valid requester at or after the pointer, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 0;
        scan_idx  = 0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
            if (!grant_vld && req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (!can_accept) grant_vld = 1'b0;
    end

    // Accept strobe is one-hot on the granted requester, zero otherwise.
    always_comb begin
        req_ready = '0;
        if (grant_vld) req_ready[grant_idx] = 1'b1;
    end

    // Next-state: a grant loads the operand (even while retiring a result);
    // a retiring result with no grant empties the register.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (state_q == BUSY && rsp_ready) begin
            cnt_d = cnt_q + CNTW'(1);
        end
        if (grant_vld) begin
            state_d = BUSY;
            op_d    = req_gray[grant_idx*WIDTH +: WIDTH];
            id_d    = IDW'(grant_idx);
            ptr_d   = (grant_idx == NREQ - 1) ? '0 : IDW'(grant_idx + 1);
        end else if (state_q == BUSY && rsp_ready) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers; reset discards any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    gray2bin_arbiter_conv #(.WIDTH(WIDTH)) u_conv (
        .gray_i (op_q),
        .bin_o  (rsp_bin)
    );

    assign rsp_valid  = (state_q == BUSY);
    assign rsp_id     = id_q;
    assign conv_count = cnt_q;

endmodule

// File: tb/tb_gray2bin_arbiter.sv
// Bench for gray2bin_arbiter: constant vector table, directed corner cases
// and random traffic checked against a transaction-level reference model.
module tb_gray2bin_arbiter;

    localparam int W = 4;
    localparam int N = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N*W-1:0] req_gray = '0;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic [W-1:0]  rsp_bin;
    logic [1:0]    rsp_id;
    logic          rsp_ready = 1'b0;
    logic [CW-1:0] conv_count;

    int n_chk = 0;
    int n_fail = 0;

    // reference model state
    bit         m_busy;
    logic [W-1:0] m_gray;
    int         m_id, m_ptr, m_cnt;

    always #5 clk = ~clk;

    gray2bin_arbiter #(.WIDTH(W), .NREQ(N), .IDW(2), .CNTW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_gray(req_gray),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_bin(rsp_bin),
        .rsp_id(rsp_id), .rsp_ready(rsp_ready), .conv_count(conv_count)
    );

    typedef struct {
        bit          rst;
        logic [3:0]  v;
        logic [15:0] g;
        bit          r;
        logic [3:0]  er;
        bit          ev;
        logic [3:0]  eb;
        logic [1:0]  eid;
        logic [3:0]  ec;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        int v, b;
        v = int'(g);
        b = 0;
        for (int s = 0; s < W; s++) b = b ^ (v >> s);
        return W'(b);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_gray = '0; m_id = 0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic drive(input logic [3:0] v, input logic [15:0] g, input bit r);
        @(negedge clk);
        req_valid = v; req_gray = g; rsp_ready = r;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Compare the DUT against the model for this cycle, then advance the model.
    task automatic mstep(input string tag);
        int g;
        logic [N-1:0] er;
        g = -1; er = '0;
        if (!m_busy || rsp_ready)
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        if (g >= 0) er[g] = 1'b1;
        chk({tag, "_rdy"}, req_ready, er);
        chk({tag, "_vld"}, rsp_valid, m_busy);
        chk({tag, "_bin"}, rsp_bin, g2b(m_gray));
        chk({tag, "_id"},  rsp_id, m_id);
        chk({tag, "_cnt"}, conv_count, m_cnt % (1 << CW));
        if (m_busy && rsp_ready) m_cnt++;
        if (g >= 0) begin
            m_gray = req_gray[g*W +: W];
            m_id   = g;
            m_ptr  = (g + 1) % N;
            m_busy = 1;
        end else if (m_busy && rsp_ready) begin
            m_busy = 0;
        end
    endtask

    bit           pend[N];
    logic [W-1:0] gv[N];
    logic [3:0]   v_now;
    logic [15:0]  g_now;
    logic [W-1:0] held_bin;

    initial begin
        //          rst  v      g         r  er     ev eb    id  cnt
        tbl[0]  = '{1, 4'b0100, 16'h0600, 1, 4'b0100, 0, 4'h0, 0, 0};
        tbl[1]  = '{0, 4'b0000, 16'h0600, 1, 4'b0000, 1, 4'h4, 2, 0};
        tbl[2]  = '{0, 4'b0000, 16'h0000, 1, 4'b0000, 0, 4'h4, 2, 1};
        tbl[3]  = '{1, 4'b1111, 16'h5F38, 1, 4'b0001, 0, 4'h0, 0, 0};
        tbl[4]  = '{0, 4'b1111, 16'h5F38, 1, 4'b0010, 1, 4'hF, 0, 0};
        tbl[5]  = '{0, 4'b1111, 16'h5F38, 1, 4'b0100, 1, 4'h2, 1, 1};
        tbl[6]  = '{0, 4'b1111, 16'h5F38, 1, 4'b1000, 1, 4'hA, 2, 2};
        tbl[7]  = '{0, 4'b1111, 16'h5F38, 1, 4'b0001, 1, 4'h6, 3, 3};
        tbl[8]  = '{0, 4'b1111, 16'h5F38, 1, 4'b0010, 1, 4'hF, 0, 4};
        tbl[9]  = '{0, 4'b1111, 16'h5F38, 1, 4'b0100, 1, 4'h2, 1, 5};
        tbl[10] = '{0, 4'b1111, 16'h5F38, 1, 4'b1000, 1, 4'hA, 2, 6};
        tbl[11] = '{0, 4'b0000, 16'h5F38, 1, 4'b0000, 1, 4'h6, 3, 7};
        tbl[12] = '{0, 4'b0000, 16'h5F38, 1, 4'b0000, 0, 4'h6, 3, 8};

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].rst) do_reset();
            drive(tbl[i].v, tbl[i].g, tbl[i].r);
            chk($sformatf("tbl%0d_rdy", i), req_ready, tbl[i].er);
            chk($sformatf("tbl%0d_vld", i), rsp_valid, tbl[i].ev);
            chk($sformatf("tbl%0d_bin", i), rsp_bin, tbl[i].eb);
            chk($sformatf("tbl%0d_id", i), rsp_id, tbl[i].eid);
            chk($sformatf("tbl%0d_cnt", i), conv_count, tbl[i].ec);
        end

        // backpressure: accept, hold 5 cycles with a competing request, release
        do_reset();
        drive(4'b0001, 16'h0009, 0); mstep("bp_acc");
        drive(4'b0010, 16'h00C9, 0); mstep("bp_h0");
        held_bin = rsp_bin;
        for (int i = 1; i < 5; i++) begin
            drive(4'b0010, 16'h00C9, 0); mstep($sformatf("bp_h%0d", i));
            chk("bp_stable_bin", rsp_bin, held_bin);
            chk("bp_no_ready", req_ready, 4'b0000);
        end
        drive(4'b0010, 16'h00C9, 1); mstep("bp_rel");
        chk("bp_b2b_ready", req_ready, 4'b0010);
        drive(4'b0000, 16'h0000, 1); mstep("bp_after");
        chk("bp_cnt", conv_count, 1);

        // fairness: pointer parked at 2, then 1 and 3 compete
        do_reset();
        drive(4'b0010, 16'h0030, 1); mstep("fr_p");
        drive(4'b1010, 16'h7030, 1); mstep("fr_a");
        chk("fr_g3", req_ready, 4'b1000);
        drive(4'b0011, 16'h0035, 1); mstep("fr_b");
        chk("fr_g0", req_ready, 4'b0001);
        drive(4'b0010, 16'h0030, 1); mstep("fr_c");
        chk("fr_g1", req_ready, 4'b0010);

        // reset while busy and stalled
        do_reset();
        drive(4'b0100, 16'h0500, 1); mstep("rs_a");
        drive(4'b1000, 16'hE000, 0); mstep("rs_b");
        drive(4'b0000, 16'h0000, 0); mstep("rs_c");
        #2 rst_n = 1'b0;
        #1;
        chk("rs_vld", rsp_valid, 0);
        chk("rs_cnt", conv_count, 0);
        chk("rs_id", rsp_id, 0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        drive(4'b0011, 16'h0021, 1); mstep("rs_after");
        chk("rs_g0", req_ready, 4'b0001);

        // counter wrap with a 4-bit counter: 17 handshakes
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(4'b1111, 16'h5F38, 1); mstep("wr");
        end
        drive(4'b0000, 16'h0000, 1); mstep("wr_t");
        drive(4'b0000, 16'h0000, 1); mstep("wr_e");
        chk("wrap_cnt", conv_count, 1);

        // random traffic; requesters hold until accepted
        do_reset();
        for (int i = 0; i < N; i++) begin pend[i] = 0; gv[i] = '0; end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    pend[i] = 1;
                    gv[i] = W'($urandom);
                end
            v_now = '0; g_now = '0;
            for (int i = 0; i < N; i++) begin
                v_now[i] = pend[i];
                g_now[i*W +: W] = gv[i];
            end
            drive(v_now, g_now, 1'($urandom_range(0, 3) != 0));
            mstep("rnd");
            for (int i = 0; i < N; i++) if (req_ready[i]) pend[i] = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
